ifetch_ctrl: RTL

Instruction fetch controller that drives the address port of the combinational-read instruction memory and buffers fetched words in a small prefetch FIFO. It presents them to the decode stage over a valid/ready handshake. It owns the fetch PC: sequential increment, redirect on branch/trap with flush, and a fault stop on a misaligned PC. It sits between `imem` and the core's decode stage.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_fifo.sv | 64 ++++++
 rtl/ifetch_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch controller and its prefetch FIFO.
package ifetch_pkg;

    localparam int unsigned INST_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        FAULTED = 1'b1
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of fetch entries: a push is visible at the head one cycle later.
// Simultaneous push/pop is allowed when full; flush empties it synchronously.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wr_entry,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t            mem_q [DEPTH];
    logic         [PW-1:0]   wr_ptr_q;
    logic         [PW-1:0]   rd_ptr_q;
    logic         [CW-1:0]   count_q;

    // Storage needs no reset: head is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch PC, RUN/FAULTED FSM and push/pop control around the prefetch FIFO.
// One-cycle fetch-to-decode latency; decode back-pressure stalls the PC once the FIFO is full.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        inst_fault
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    ifetch_state_e   state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            push, pop, misaligned;
    fetch_entry_t    wr_entry, head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign misaligned = (fetch_pc_q[1:0] != 2'b00);
    assign pop        = inst_valid && inst_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        wr_entry.pc    = fetch_pc_q;
        wr_entry.data  = misaligned ? 32'h0 : imem_rdata;
        wr_entry.fault = misaligned;

        if (redirect_valid) begin
            state_d    = RUN;
            fetch_pc_d = redirect_pc;
        end else if (state_q == RUN && fetch_en && (fifo_count < DEPTH_C || pop)) begin
            push = 1'b1;
            // A faulting PC is parked until a redirect; it is never advanced.
            if (misaligned) begin
                state_d = FAULTED;
            end else begin
                fetch_pc_d = fetch_pc_q + INST_BYTES;
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_full && push && !pop));

    assign imem_addr  = fetch_pc_q;
    assign inst_valid = !fifo_empty;
    assign inst_pc    = head.pc;
    assign inst_data  = head.data;
    assign inst_fault = head.fault;

endmodule
